// File: rtl/pipe_stage_fwd_reg_if.sv
// Bundle of stage-control, payload, operand and forwarding signals for pipe_stage_fwd_reg.
// The master modport drives the stage inputs. The slave modport is the stage itself.
interface pipe_stage_fwd_reg_if #(
    parameter int unsigned PAYLOAD_W = 96,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_OPS   = 2,
    parameter int unsigned NUM_FWD   = 3,
    parameter int unsigned CNT_W     = 16
);
    logic                         run;
    logic                         bubble;
    logic                         flush;
    logic                         in_valid;
    logic [PAYLOAD_W-1:0]         in_payload;
    logic [NUM_OPS*DATA_W-1:0]    in_op;
    logic [NUM_OPS*NUM_FWD-1:0]   in_fwd_sel;
    logic [NUM_FWD*DATA_W-1:0]    fwd_data;
    logic                         out_valid;
    logic [PAYLOAD_W-1:0]         out_payload;
    logic [NUM_OPS*DATA_W-1:0]    out_op;
    logic [NUM_OPS*NUM_FWD-1:0]   out_fwd_sel;
    logic [CNT_W-1:0]             bubble_cnt;

    modport master (
        output run, bubble, flush, in_valid, in_payload, in_op, in_fwd_sel, fwd_data,
        input  out_valid, out_payload, out_op, out_fwd_sel, bubble_cnt
    );

    modport slave (
        input  run, bubble, flush, in_valid, in_payload, in_op, in_fwd_sel, fwd_data,
        output out_valid, out_payload, out_op, out_fwd_sel, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_fwd_reg.sv
// ID->EX class pipeline register with per-operand forwarding muxes after the flops.
// While stalled, a forwarded value is frozen into the operand register, so it survives
// the source stage moving on. The stage also keeps a saturating count of inserted bubbles.
module pipe_stage_fwd_reg #(
    parameter int unsigned PAYLOAD_W = 96,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_OPS   = 2,
    parameter int unsigned NUM_FWD   = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_stage_fwd_reg_if.slave   bus
);

    logic                                 r_valid;
    logic [PAYLOAD_W-1:0]                 r_payload;
    logic [NUM_OPS-1:0][DATA_W-1:0]       r_op;
    logic [NUM_OPS-1:0][NUM_FWD-1:0]      r_sel;
    logic [CNT_W-1:0]                     r_cnt;

    logic [NUM_OPS-1:0][DATA_W-1:0]       w_in_op;
    logic [NUM_OPS-1:0][NUM_FWD-1:0]      w_in_sel;
    logic [NUM_FWD-1:0][DATA_W-1:0]       w_fwd;
    logic [NUM_OPS-1:0][DATA_W-1:0]       w_op;
    logic                                 w_clear;

    assign w_in_op  = bus.in_op;
    assign w_in_sel = bus.in_fwd_sel;
    assign w_fwd    = bus.fwd_data;
    assign w_clear  = bus.flush | bus.bubble;

    // Forward mux: the highest set select bit (the newest source) wins, so scan upward and overwrite.
    always_comb begin
        for (int i = 0; i < NUM_OPS; i++) begin
            w_op[i] = r_op[i];
            for (int k = 0; k < NUM_FWD; k++) begin
                if (r_sel[i][k]) begin
                    w_op[i] = w_fwd[k];
                end
            end
        end
    end

    // Stage register: priority is flush/bubble clear, then load, then hold with the operand freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
            r_op      <= '0;
            r_sel     <= '0;
        end else if (w_clear) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
            r_op      <= '0;
            r_sel     <= '0;
        end else if (bus.run) begin
            r_valid   <= bus.in_valid;
            r_payload <= bus.in_payload;
            r_op      <= w_in_op;
            r_sel     <= w_in_sel;
        end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (r_sel[i] != '0) begin
                    r_op[i]  <= w_op[i];
                    r_sel[i] <= '0;
                end
            end
        end
    end

    // Bubble counter: flush and bubble on the same edge count once. The count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_clear && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.out_valid   = r_valid;
    assign bus.out_payload = r_payload;
    assign bus.out_op      = w_op;
    assign bus.out_fwd_sel = r_sel;
    assign bus.bubble_cnt  = r_cnt;

endmodule

// File: tb/tb_pipe_stage_fwd_reg.sv
// Testbench for pipe_stage_fwd_reg: directed scenarios plus randomized cycles, checked against a
// behavioural model of the stage.
module tb_pipe_stage_fwd_reg;

    localparam int unsigned PW = 96;
    localparam int unsigned DW = 32;
    localparam int unsigned NO = 2;
    localparam int unsigned NF = 3;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stage_fwd_reg_if #(.PAYLOAD_W(PW), .DATA_W(DW), .NUM_OPS(NO), .NUM_FWD(NF), .CNT_W(CW)) bus();

    pipe_stage_fwd_reg #(
        .PAYLOAD_W(PW), .DATA_W(DW), .NUM_OPS(NO), .NUM_FWD(NF), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic          m_valid;
    logic [PW-1:0] m_payload;
    logic [DW-1:0] m_op  [NO];
    logic [NF-1:0] m_sel [NO];
    int            m_cnt;

    function automatic logic [DW-1:0] fwd_src(int k);
        return bus.fwd_data[k*DW +: DW];
    endfunction

    // Newest (highest-index) requested source wins; no request means the stored operand.
    function automatic logic [DW-1:0] exp_op(int i);
        logic [DW-1:0] v;
        logic found;
        v = m_op[i];
        found = 1'b0;
        for (int k = NF - 1; k >= 0; k--) begin
            if (!found && m_sel[i][k]) begin
                v = fwd_src(k);
                found = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_payload = '0;
        m_cnt = 0;
        for (int i = 0; i < NO; i++) begin
            m_op[i] = '0;
            m_sel[i] = '0;
        end
    endfunction

    function automatic void model_edge();
        logic [DW-1:0] frozen [NO];
        for (int i = 0; i < NO; i++) frozen[i] = exp_op(i);
        if (bus.flush || bus.bubble) begin
            m_valid = 1'b0;
            m_payload = '0;
            for (int i = 0; i < NO; i++) begin
                m_op[i] = '0;
                m_sel[i] = '0;
            end
            if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        end else if (bus.run) begin
            m_valid = bus.in_valid;
            m_payload = bus.in_payload;
            for (int i = 0; i < NO; i++) begin
                m_op[i] = bus.in_op[i*DW +: DW];
                m_sel[i] = bus.in_fwd_sel[i*NF +: NF];
            end
        end else begin
            for (int i = 0; i < NO; i++) begin
                if (m_sel[i] != 0) begin
                    m_op[i] = frozen[i];
                    m_sel[i] = '0;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NO*DW-1:0] e_op;
        logic [NO*NF-1:0] e_sel;
        for (int i = 0; i < NO; i++) begin
            e_op[i*DW +: DW] = exp_op(i);
            e_sel[i*NF +: NF] = m_sel[i];
        end
        check({tag, ".valid"}, 128'(bus.out_valid), 128'(m_valid));
        check({tag, ".payload"}, 128'(bus.out_payload), 128'(m_payload));
        check({tag, ".op"}, 128'(bus.out_op), 128'(e_op));
        check({tag, ".sel"}, 128'(bus.out_fwd_sel), 128'(e_sel));
        check({tag, ".cnt"}, 128'(bus.bubble_cnt), 128'(m_cnt));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rand_data();
        bus.in_valid   = 1'($urandom);
        bus.in_payload = {$urandom, $urandom, $urandom};
        bus.in_op      = {$urandom, $urandom};
        bus.in_fwd_sel = 6'($urandom);
        bus.fwd_data   = {$urandom, $urandom, $urandom};
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #2;
        check_all(tag);
        rst = 1'b0;
    endtask

    int cnt_before;

    initial begin
        rst = 1'b1;
        bus.run = 1'b0;
        bus.bubble = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_payload = '0;
        bus.in_op = '0;
        bus.in_fwd_sel = '0;
        bus.fwd_data = '0;
        model_reset();
        #1;
        check_all("reset_init");
        #2;
        rst = 1'b0;

        // Test 1: bubble and load, then a reset pulse mid-cycle clears everything at once
        bus.bubble = 1'b1;
        step("t1_bubble");
        bus.bubble = 1'b0;
        bus.run = 1'b1;
        rand_data();
        bus.in_valid = 1'b1;
        step("t1_load");
        async_reset("t1_async_reset");

        // Test 2: load with a multi-hot select; source 2 beats source 0
        bus.run = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_payload = {$urandom, $urandom, $urandom};
        bus.in_op = {$urandom, 32'h11};
        bus.in_fwd_sel = {3'b000, 3'b101};
        bus.fwd_data = {32'hC, 32'hB, 32'hA};
        step("t2_load");
        check("t2_op0", 128'(bus.out_op[DW-1:0]), 128'(32'hC));
        check("t2_op1", 128'(bus.out_op[2*DW-1:DW]), 128'(bus.in_op[2*DW-1:DW]));

        // Test 3: stall freezes the forwarded value even after the source changes
        bus.run = 1'b0;
        rand_data();
        bus.fwd_data = {32'hC, 32'hB, 32'hA};
        step("t3_stall1");
        bus.fwd_data[3*DW-1:2*DW] = 32'hD;
        step("t3_stall2");
        check("t3_op0_c2", 128'(bus.out_op[DW-1:0]), 128'(32'hC));
        check("t3_sel0_c2", 128'(bus.out_fwd_sel[NF-1:0]), 128'(3'b000));
        step("t3_stall3");
        check("t3_op0_c3", 128'(bus.out_op[DW-1:0]), 128'(32'hC));

        // Reset during a stall discards the frozen operand
        bus.run = 1'b1;
        rand_data();
        bus.in_fwd_sel = {3'b011, 3'b100};
        step("rs_load");
        bus.run = 1'b0;
        step("rs_freeze");
        async_reset("rs_async_reset");

        // Test 4: a bubble during a stall clears the stage
        bus.run = 1'b1;
        rand_data();
        bus.in_valid = 1'b1;
        step("t4_load");
        bus.run = 1'b0;
        bus.bubble = 1'b1;
        cnt_before = m_cnt;
        step("t4_bubble");
        check("t4_valid", 128'(bus.out_valid), 128'(1'b0));
        check("t4_cnt", 128'(bus.bubble_cnt), 128'(cnt_before + 1));
        bus.bubble = 1'b0;

        // Test 5: flush and bubble on the same edge count once
        bus.run = 1'b1;
        rand_data();
        bus.in_valid = 1'b1;
        step("t5_load");
        bus.flush = 1'b1;
        bus.bubble = 1'b1;
        cnt_before = m_cnt;
        step("t5_flush_bubble");
        check("t5_cnt", 128'(bus.bubble_cnt), 128'(cnt_before + 1));
        bus.flush = 1'b0;
        bus.bubble = 1'b0;

        // Random cycles
        for (int n = 0; n < 300; n++) begin
            bus.run = 1'($urandom);
            bus.bubble = ($urandom_range(0, 11) == 0);
            bus.flush = ($urandom_range(0, 11) == 0);
            rand_data();
            step("rand");
        end

        // Test 6: counter saturates at all-ones and holds
        async_reset("t6_reset");
        bus.bubble = 1'b1;
        for (int n = 0; n < 20; n++) begin
            rand_data();
            bus.run = 1'($urandom);
            step("t6_bubble");
        end
        check("t6_sat", 128'(bus.bubble_cnt), 128'(4'hF));
        bus.bubble = 1'b0;
        bus.run = 1'b1;
        step("t6_hold");
        check("t6_sat_hold", 128'(bus.bubble_cnt), 128'(4'hF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
